// File: rtl/snd_player_if.sv
// Note-request channel between the game controller and snd_player.
// The melGo line exists only when SND_MELODY_EN is defined.
interface snd_player_if;
    // Handshake: a note is accepted on a rising clk edge where sndVld and sndRdy are both 1;
    // sndVld while sndRdy=0 is dropped, never queued. sndStop aborts synchronously and wins over all.
    logic [3:0] sndCode;
    logic       sndVld;
    logic       sndRdy;
    logic       sndStop;
`ifdef SND_MELODY_EN
    logic       melGo;

    modport master (output sndCode, output sndVld, output sndStop, output melGo, input sndRdy);
    modport slave  (input sndCode, input sndVld, input sndStop, input melGo, output sndRdy);
`else
    modport master (output sndCode, output sndVld, output sndStop, input sndRdy);
    modport slave  (input sndCode, input sndVld, input sndStop, output sndRdy);
`endif
endinterface

// File: rtl/snd_player.sv
// Single-note square-wave player (IDLE -> PLAY -> GAP) driven by 4-bit chromatic note codes.
// Define SND_MELODY_EN to add the built-in 8-note melody ROM and the melGo start line.
module snd_player #(
    parameter int CLK_HZ   = 50000000,
    parameter int NOTE_CYC = 12500000,
    parameter int GAP_CYC  = 1250000
) (
    input  logic               clk,
    input  logic               resetN,
    snd_player_if.slave        snd,
    output logic               busy,
    output logic               toneOut,
    output logic               noteDone,
    output logic [1:0]         dbg_state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, GAP = 2'd2} state_t;

    localparam real SEMI = 1.0594630943592953;

    // Half-period in clk cycles for code k (A4 = code 10 = 440 Hz); rests map to 1.
    function automatic int half_of(input int k);
        real f;
        int  h;
        f = 440.0;
        for (int i = 10; i < k; i++) f = f * SEMI;
        for (int i = k; i < 10; i++) f = f / SEMI;
        h = $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
        if (k < 1 || k > 12 || h < 1) h = 1;
        return h;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    localparam int HALF_TAB [0:15] = '{
        half_of(0),  half_of(1),  half_of(2),  half_of(3),
        half_of(4),  half_of(5),  half_of(6),  half_of(7),
        half_of(8),  half_of(9),  half_of(10), half_of(11),
        half_of(12), half_of(13), half_of(14), half_of(15)
    };
    localparam int CW = $clog2(max3(NOTE_CYC, GAP_CYC, half_of(1)) + 1);
    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

`ifdef SND_MELODY_EN
    function automatic logic [3:0] mel_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return 4'd7;
            3'd1:    return 4'd7;
            3'd2:    return 4'd2;
            3'd3:    return 4'd3;
            3'd4:    return 4'd9;
            3'd5:    return 4'd9;
            3'd6:    return 4'd5;
            default: return 4'd7;
        endcase
    endfunction

    logic       mel_act_q, mel_act_d;
    logic [2:0] mel_idx_q, mel_idx_d;
`endif

    state_t        state_q, state_d;
    logic [3:0]    code_q, code_d;
    logic [CW-1:0] dur_q, dur_d;
    logic [CW-1:0] half_q, half_d;
    logic          tone_q, tone_d;
    logic          is_note;
    logic [CW-1:0] half_last;
    logic          note_end;

    assign is_note   = (code_q >= 4'd1) && (code_q <= 4'd12);
    assign half_last = CW'(HALF_TAB[code_q] - 1);
    // With no gap configured the note finishes in its last PLAY cycle.
    assign note_end  = ((state_q == GAP) && (dur_q == GAP_LAST)) ||
                       ((GAP_CYC == 0) && (state_q == PLAY) && (dur_q == NOTE_LAST));

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        dur_d   = dur_q;
        half_d  = half_q;
        tone_d  = tone_q;
`ifdef SND_MELODY_EN
        mel_act_d = mel_act_q;
        mel_idx_d = mel_idx_q;
`endif
        case (state_q)
            IDLE: begin
                dur_d  = '0;
                half_d = '0;
                tone_d = 1'b0;
`ifdef SND_MELODY_EN
                if (snd.melGo) begin
                    code_d    = mel_rom(3'd0);
                    mel_act_d = 1'b1;
                    mel_idx_d = 3'd0;
                    state_d   = PLAY;
                end else if (snd.sndVld) begin
                    code_d  = snd.sndCode;
                    state_d = PLAY;
                end
`else
                if (snd.sndVld) begin
                    code_d  = snd.sndCode;
                    state_d = PLAY;
                end
`endif
            end
            PLAY: begin
                if (dur_q == NOTE_LAST) begin
                    dur_d  = '0;
                    half_d = '0;
                    tone_d = 1'b0;
                    if (GAP_CYC != 0) state_d = GAP;
                end else begin
                    dur_d = dur_q + 1'b1;
                    if (!is_note) begin
                        tone_d = 1'b0;
                    end else if (half_q == half_last) begin
                        half_d = '0;
                        tone_d = ~tone_q;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end
            end
            GAP: begin
                tone_d = 1'b0;
                dur_d  = (dur_q == GAP_LAST) ? '0 : dur_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (note_end) begin
            state_d = IDLE;
`ifdef SND_MELODY_EN
            if (mel_act_q) begin
                if (mel_idx_q == 3'd7) begin
                    mel_act_d = 1'b0;
                    mel_idx_d = 3'd0;
                end else begin
                    mel_idx_d = mel_idx_q + 3'd1;
                    code_d    = mel_rom(mel_idx_q + 3'd1);
                    state_d   = PLAY;
                end
            end
`endif
        end

        if (snd.sndStop) begin
            state_d = IDLE;
            dur_d   = '0;
            half_d  = '0;
            tone_d  = 1'b0;
`ifdef SND_MELODY_EN
            mel_act_d = 1'b0;
            mel_idx_d = 3'd0;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            code_q  <= 4'd0;
            dur_q   <= '0;
            half_q  <= '0;
            tone_q  <= 1'b0;
`ifdef SND_MELODY_EN
            mel_act_q <= 1'b0;
            mel_idx_q <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            dur_q   <= dur_d;
            half_q  <= half_d;
            tone_q  <= tone_d;
`ifdef SND_MELODY_EN
            mel_act_q <= mel_act_d;
            mel_idx_q <= mel_idx_d;
`endif
        end
    end

    assign snd.sndRdy  = (state_q == IDLE);
    assign busy        = (state_q == PLAY) || (state_q == GAP);
    assign toneOut     = tone_q;
    assign noteDone    = note_end;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_snd_player.sv
// Directed bench for snd_player: a timing instance (NOTE_CYC=100, GAP_CYC=10) and a
// tone instance (NOTE_CYC=4000, GAP_CYC=0) long enough to observe square-wave periods.
module tb_snd_player;
    logic       clk;
    logic       resetN;
    logic       m_busy, m_tone, m_done;
    logic [1:0] m_state;
    logic       t_busy, t_tone, t_done;
    logic [1:0] t_state;

    int n_cmp;
    int n_err;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0] code;
        int         half;
    } vec_t;
    vec_t vecs[8];

    snd_player_if m_if();
    snd_player_if t_if();

    snd_player #(.CLK_HZ(1000000), .NOTE_CYC(100), .GAP_CYC(10)) u_main (
        .clk(clk), .resetN(resetN), .snd(m_if),
        .busy(m_busy), .toneOut(m_tone), .noteDone(m_done), .dbg_state_o(m_state)
    );

    snd_player #(.CLK_HZ(1000000), .NOTE_CYC(4000), .GAP_CYC(0)) u_tone (
        .clk(clk), .resetN(resetN), .snd(t_if),
        .busy(t_busy), .toneOut(t_tone), .noteDone(t_done), .dbg_state_o(t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_idle_main(input string tag);
        check({tag, " m_rdy"}, int'(m_if.sndRdy), 1);
        check({tag, " m_busy"}, int'(m_busy), 0);
        check({tag, " m_tone"}, int'(m_tone), 0);
        check({tag, " m_done"}, int'(m_done), 0);
        check({tag, " m_state"}, int'(m_state), 0);
    endtask

    // Accept one note on the timing instance and follow it to the end of its gap.
    task automatic run_main(input logic [3:0] code, input string tag);
        int done_cnt, done_at, rdy_at, tone_hi;
        m_if.sndCode = code;
        m_if.sndVld  = 1'b1;
        tick();
        m_if.sndVld  = 1'b0;
        check({tag, " rdy after accept"}, int'(m_if.sndRdy), 0);
        done_cnt = 0; done_at = -1; rdy_at = -1; tone_hi = 0;
        for (int k = 0; k <= 120; k++) begin
            if (k > 0) tick();
            if (m_tone) tone_hi++;
            if (m_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (m_if.sndRdy && rdy_at < 0) rdy_at = k;
        end
        check({tag, " done count"}, done_cnt, 1);
        check({tag, " done cycle"}, done_at, 109);
        check({tag, " rdy cycle"}, rdy_at, 110);
        check({tag, " tone high cycles"}, tone_hi, 0);
    endtask

    // Accept one note on the tone instance; notes are measured then stopped, rests run to the end.
    task automatic run_tone(input logic [3:0] code, input int half, input string tag);
        int k1, k2, done_cnt, done_at, rdy_at, tone_hi, limit;
        logic prev;
        t_if.sndCode = code;
        t_if.sndVld  = 1'b1;
        tick();
        t_if.sndVld  = 1'b0;
        k1 = -1; k2 = -1; done_cnt = 0; done_at = -1; rdy_at = -1; tone_hi = 0; prev = 1'b0;
        limit = (half > 0) ? 2 * half + 5 : 4010;
        for (int k = 0; k <= limit; k++) begin
            if (k > 0) tick();
            if (t_tone && !prev && k1 < 0) k1 = k;
            if (!t_tone && prev && k2 < 0) k2 = k;
            prev = t_tone;
            if (t_tone) tone_hi++;
            if (t_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (t_if.sndRdy && rdy_at < 0) rdy_at = k;
        end
        if (half > 0) begin
            check({tag, " first toggle"}, k1, half);
            check({tag, " second toggle"}, k2, 2 * half);
            check({tag, " no done mid-note"}, done_cnt, 0);
            t_if.sndStop = 1'b1;
            tick();
            t_if.sndStop = 1'b0;
            check({tag, " rdy after stop"}, int'(t_if.sndRdy), 1);
            check({tag, " tone after stop"}, int'(t_tone), 0);
        end else begin
            check({tag, " rest tone high cycles"}, tone_hi, 0);
            check({tag, " rest done count"}, done_cnt, 1);
            check({tag, " rest done cycle"}, done_at, 3999);
            check({tag, " rest rdy cycle"}, rdy_at, 4000);
        end
    endtask

    initial begin
        int done_cnt, busy_hi;
        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{4'd10, 1136};
        vecs[1] = '{4'd1,  1911};
        vecs[2] = '{4'd12, 1012};
        vecs[3] = '{4'd7,  1351};
        vecs[4] = '{4'd8,  1276};
        vecs[5] = '{4'd0,  0};
        vecs[6] = '{4'd13, 0};
        vecs[7] = '{4'd15, 0};

        resetN = 1'b0;
        m_if.sndCode = 4'd0; m_if.sndVld = 1'b0; m_if.sndStop = 1'b0;
        t_if.sndCode = 4'd0; t_if.sndVld = 1'b0; t_if.sndStop = 1'b0;
`ifdef SND_MELODY_EN
        m_if.melGo = 1'b0;
        t_if.melGo = 1'b0;
`endif
        tick();
        tick();
        check_idle_main("reset");
        check("reset t_rdy", int'(t_if.sndRdy), 1);
        check("reset t_tone", int'(t_tone), 0);
        check("reset t_state", int'(t_state), 0);
        resetN = 1'b1;
        tick();
        check_idle_main("post reset");

        for (int i = 0; i < 8; i++) begin
            run_main(vecs[i].code, $sformatf("vec%0d main", i));
            run_tone(vecs[i].code, vecs[i].half, $sformatf("vec%0d tone", i));
        end

        // A second request during PLAY is dropped.
        m_if.sndCode = 4'd1;
        m_if.sndVld  = 1'b1;
        tick();
        m_if.sndVld  = 1'b0;
        done_cnt = 0;
        for (int k = 0; k <= 120; k++) begin
            if (k > 0) tick();
            if (k == 50) begin
                m_if.sndCode = 4'd5;
                m_if.sndVld  = 1'b1;
            end
            if (k == 52) m_if.sndVld = 1'b0;
            if (m_done) done_cnt++;
        end
        check("ignored vld done count", done_cnt, 1);
        check_idle_main("ignored vld end");

        // sndStop at cycle 40 of PLAY.
        m_if.sndCode = 4'd10;
        m_if.sndVld  = 1'b1;
        tick();
        m_if.sndVld  = 1'b0;
        for (int k = 1; k <= 40; k++) tick();
        m_if.sndStop = 1'b1;
        tick();
        m_if.sndStop = 1'b0;
        check_idle_main("stop");
        done_cnt = 0;
        busy_hi = 0;
        for (int k = 0; k < 120; k++) begin
            tick();
            if (m_done) done_cnt++;
            if (m_busy) busy_hi++;
        end
        check("stop no done", done_cnt, 0);
        check("stop stays idle", busy_hi, 0);
        run_main(4'd3, "after stop");

        // sndStop beats sndVld in IDLE.
        m_if.sndCode = 4'd4;
        m_if.sndVld  = 1'b1;
        m_if.sndStop = 1'b1;
        tick();
        m_if.sndVld  = 1'b0;
        m_if.sndStop = 1'b0;
        check_idle_main("stop beats vld");

        // Stop while the tone output is high.
        t_if.sndCode = 4'd12;
        t_if.sndVld  = 1'b1;
        tick();
        t_if.sndVld  = 1'b0;
        for (int k = 1; k <= 1020; k++) tick();
        check("tone high before stop", int'(t_tone), 1);
        t_if.sndStop = 1'b1;
        tick();
        t_if.sndStop = 1'b0;
        check("tone low after stop", int'(t_tone), 0);
        check("tone rdy after stop", int'(t_if.sndRdy), 1);

        // Asynchronous reset at cycle 30 of PLAY, then accept on the first edge after release.
        m_if.sndCode = 4'd10;
        m_if.sndVld  = 1'b1;
        tick();
        m_if.sndVld  = 1'b0;
        for (int k = 1; k <= 30; k++) tick();
        check("busy before reset", int'(m_busy), 1);
        resetN = 1'b0;
        #1;
        check_idle_main("async reset");
        tick();
        resetN = 1'b1;
        run_main(4'd2, "post reset note");

`ifdef SND_MELODY_EN
        // Melody on the timing instance: melGo wins over sndVld, melGo while busy ignored.
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(109 + 110 * i));
        m_if.melGo   = 1'b1;
        m_if.sndCode = 4'd1;
        m_if.sndVld  = 1'b1;
        tick();
        m_if.melGo   = 1'b0;
        m_if.sndVld  = 1'b0;
        check("mel rdy after start", int'(m_if.sndRdy), 0);
        begin
            int rdy_early, rdy_at;
            done_cnt = 0; rdy_early = 0; rdy_at = -1;
            for (int k = 0; k <= 900; k++) begin
                if (k > 0) tick();
                if (k == 500) m_if.melGo = 1'b1;
                if (k == 501) m_if.melGo = 1'b0;
                if (m_done) begin
                    done_cnt++;
                    if (exp_q.size() == 0) check("mel extra done", k, -1);
                    else check("mel done cycle", k, int'(exp_q.pop_front()));
                end
                if (m_if.sndRdy && k < 880) rdy_early++;
                if (m_if.sndRdy && rdy_at < 0) rdy_at = k;
            end
            check("mel done count", done_cnt, 8);
            check("mel rdy low throughout", rdy_early, 0);
            check("mel rdy cycle", rdy_at, 880);
        end

        // Melody on the tone instance: each note's first toggle gives its half-period.
        exp_q.delete();
        exp_q.push_back(32'd1351); exp_q.push_back(32'd1351);
        exp_q.push_back(32'd1804); exp_q.push_back(32'd1703);
        exp_q.push_back(32'd1204); exp_q.push_back(32'd1204);
        exp_q.push_back(32'd1517); exp_q.push_back(32'd1351);
        t_if.melGo   = 1'b1;
        t_if.sndCode = 4'd1;
        t_if.sndVld  = 1'b1;
        tick();
        t_if.melGo   = 1'b0;
        t_if.sndVld  = 1'b0;
        begin
            int last_note, rises, rdy_at;
            logic prev;
            last_note = -1; rises = 0; rdy_at = -1; done_cnt = 0; prev = 1'b0;
            for (int k = 0; k <= 32005; k++) begin
                if (k > 0) tick();
                if (t_tone && !prev && (k / 4000) != last_note) begin
                    last_note = k / 4000;
                    rises++;
                    if (exp_q.size() == 0) check("mel tone extra note", k % 4000, -1);
                    else check("mel tone half", k % 4000, int'(exp_q.pop_front()));
                end
                prev = t_tone;
                if (t_done) done_cnt++;
                if (t_if.sndRdy && rdy_at < 0) rdy_at = k;
            end
            check("mel tone notes", rises, 8);
            check("mel tone done count", done_cnt, 8);
            check("mel tone rdy cycle", rdy_at, 32000);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
